// File: rtl/ct_f_spsram_256x100_ctrl_if.sv
// ct_f_spsram_256x100_ctrl_if
// Bundles the request channel, the read-response channel and the SRAM
// wrapper strobes used by ct_f_spsram_256x100_ctrl.
//   req_*  : valid/ready request (write when req_wr=1, else read)
//   rsp_*  : valid/ready read response
//   sram_* : active-low strobes, address and data to the SRAM wrapper,
//            sram_q returns read data the cycle after a read strobe
// Modports: slave  = controller side (drives req_rdy, rsp_*, sram_* outs)
//           master = requester/SRAM side (drives req_*, rsp_rdy, sram_q)
interface ct_f_spsram_256x100_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 100
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
    output req_rdy, rsp_vld, rsp_data, sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
    input  req_rdy, rsp_vld, rsp_data, sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );
endinterface

// File: rtl/ct_f_spsram_256x100_ctrl.sv
// ct_f_spsram_256x100_ctrl
// Access controller in front of the 256x100 single-port SRAM wrapper.
// Turns valid/ready requests into active-low CEN/GWEN/WEN strobes, tracks the
// one-cycle read latency and queues read data in a 2-entry response FIFO.
// Ports:
//   CLK       clock
//   RST       synchronous active-high reset
//   bus       ct_f_spsram_256x100_ctrl_if.slave (request, response, SRAM side)
//   init_done array initialisation complete
// Build option: define CT_F_SPSRAM_CTRL_INIT_EN to zero the whole array after
// every reset (256-cycle sweep, requests stalled meanwhile). Without it the
// controller is usable right after reset and init_done is tied high.
module ct_f_spsram_256x100_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 100,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  ct_f_spsram_256x100_ctrl_if.slave   bus,
  output logic                        init_done
);

  localparam logic [1:0] OCC_MAX = 2'(RSP_DEPTH);

  logic                  run;
  logic                  sweep_wr;
  logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign run        = (state_q == ST_RUN);
  assign init_done  = run;
  // The sweep stays off the SRAM while reset is held.
  assign sweep_wr   = (state_q == ST_INIT) && !RST;
  assign sweep_addr = init_cnt_q;
`else
  assign run        = 1'b1;
  assign init_done  = 1'b1;
  assign sweep_wr   = 1'b0;
  assign sweep_addr = '0;
`endif

  // Occupancy = read in flight + FIFO entries; bounds outstanding reads.
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop, rd_acc, wr_acc;

  assign pop  = bus.rsp_vld && bus.rsp_rdy;
  assign push = inflight_q;   // sram_q is valid the cycle after the read strobe

  // A pop in the same cycle frees the slot a new read would need.
  assign bus.req_rdy = !RST && run && (bus.req_wr || (occ_q != OCC_MAX) || pop);
  assign rd_acc      = bus.req_vld && bus.req_rdy && !bus.req_wr;
  assign wr_acc      = bus.req_vld && bus.req_rdy &&  bus.req_wr;

  always_comb begin
    bus.sram_cen  = 1'b1;
    bus.sram_gwen = 1'b1;
    bus.sram_wen  = '1;
    bus.sram_a    = '0;
    bus.sram_d    = '0;
    if (sweep_wr) begin
      bus.sram_cen  = 1'b0;
      bus.sram_gwen = 1'b0;
      bus.sram_wen  = '0;
      bus.sram_a    = sweep_addr;
    end else if (wr_acc) begin
      bus.sram_cen  = 1'b0;
      bus.sram_gwen = 1'b0;
      bus.sram_wen  = ~bus.req_wmask;
      bus.sram_a    = bus.req_addr;
      bus.sram_d    = bus.req_wdata;
    end else if (rd_acc) begin
      bus.sram_cen  = 1'b0;
      bus.sram_a    = bus.req_addr;
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({rd_acc, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rd_acc;
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.sram_q;
  end

  assign bus.rsp_vld  = (cnt_q != 2'd0);
  assign bus.rsp_data = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ct_f_spsram_256x100_ctrl.sv
module tb_ct_f_spsram_256x100_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [99:0] exp_q [$];
  logic [99:0] ref_mem [256];
  logic [99:0] sram_arr [256];

  ct_f_spsram_256x100_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(100)) bus ();

  ct_f_spsram_256x100_ctrl dut (
    .CLK(clk), .RST(rst), .bus(bus), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM wrapper: WEN bits 24/49/74/99 gate the four 25-bit lanes.
  always @(posedge clk) begin
    if (!bus.sram_cen) begin
      if (!bus.sram_gwen) begin
        for (int k = 0; k < 4; k++)
          if (!bus.sram_wen[25*k+24]) sram_arr[bus.sram_a][25*k +: 25] <= bus.sram_d[25*k +: 25];
      end else begin
        bus.sram_q <= sram_arr[bus.sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every popped response is compared to the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.rsp_vld && bus.rsp_rdy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", bus.rsp_data, 100'hx);
      end else begin
        logic [99:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", bus.rsp_data, e);
        $display("rsp data=%h", bus.rsp_data);
      end
    end
  end

  task automatic ref_write(input logic [7:0] a, input logic [99:0] d, input logic [99:0] m);
    for (int k = 0; k < 4; k++)
      if (m[25*k+24]) ref_mem[a][25*k +: 25] = d[25*k +: 25];
  endtask

  task automatic send(input bit wr, input logic [7:0] a, input logic [99:0] d, input logic [99:0] m);
    int waited;
    waited = 0;
    bus.req_vld = 1'b1; bus.req_wr = wr; bus.req_addr = a;
    bus.req_wdata = d; bus.req_wmask = m;
    @(negedge clk);
    while (!bus.req_rdy && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("req_timeout", {99'd0, bus.req_rdy}, 100'd1);
    chk("sram_cen", {99'd0, bus.sram_cen}, 100'd0);
    chk("sram_gwen", {99'd0, bus.sram_gwen}, {99'd0, !wr});
    chk("sram_a", {92'd0, bus.sram_a}, {92'd0, a});
    chk("sram_wen", bus.sram_wen, wr ? ~m : {100{1'b1}});
    if (wr) begin
      chk("sram_d", bus.sram_d, d);
      ref_write(a, d, m);
    end else begin
      exp_q.push_back(ref_mem[a]);
    end
    $display("req wr=%0d addr=%h data=%h", wr, a, d);
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    begin
      int w;
      w = 0;
      while (!init_done && w < 300) begin
        @(posedge clk); #1;
        w++;
      end
      chk("init_timeout", {99'd0, init_done}, 100'd1);
    end
`endif
  endtask

  localparam logic [99:0] PAT  = 100'h5555555555555555555555555;
  localparam logic [99:0] ONES = {100{1'b1}};

  initial begin
    logic [99:0] m49;
    logic [99:0] lane_exp;
    bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h33;
    bus.req_wdata = ONES; bus.req_wmask = ONES;
    bus.rsp_rdy = 1'b1; bus.sram_q = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; sram_arr[i] = '0; end

    // Reset state, with a request presented to show it is held off.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_vld", {99'd0, bus.rsp_vld}, 100'd0);
    chk("rst_req_rdy", {99'd0, bus.req_rdy}, 100'd0);
    chk("rst_cen", {99'd0, bus.sram_cen}, 100'd1);
    chk("rst_gwen", {99'd0, bus.sram_gwen}, 100'd1);
    chk("rst_wen", bus.sram_wen, ONES);
    chk("rst_a", {92'd0, bus.sram_a}, 100'd0);
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    chk("rst_init_done", {99'd0, init_done}, 100'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      chk("init_a", {92'd0, bus.sram_a}, 100'(c));
      chk("init_cen", {98'd0, bus.sram_cen, bus.sram_gwen}, 100'd0);
      chk("init_wen", bus.sram_wen, 100'd0);
      chk("init_d", bus.sram_d, 100'd0);
      chk("init_rdy", {98'd0, bus.req_rdy, init_done}, 100'd0);
    end
    bus.req_vld = 1'b0;
    @(negedge clk);
    chk("init_done_rise", {99'd0, init_done}, 100'd1);
    @(posedge clk); #1;
    send(1'b0, 8'h7F, '0, '0);
    chk("init_rd7f_exp", exp_q[0], 100'd0);
`else
    chk("rst_init_done", {99'd0, init_done}, 100'd1);
    bus.req_vld = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
`endif
    repeat (3) @(posedge clk); #1;

    // Write then read on the next cycle; response one edge after the read edge.
    send(1'b1, 8'h10, PAT, ONES);
    send(1'b0, 8'h10, '0, '0);
    @(negedge clk);
    chk("lat_early", {99'd0, bus.rsp_vld}, 100'd0);
    @(negedge clk);
    chk("lat_vld", {99'd0, bus.rsp_vld}, 100'd1);
    chk("lat_data", bus.rsp_data, PAT);
    @(posedge clk); #1;

    // Lane mask: only bit 49 set writes lane 1.
    m49 = '0; m49[49] = 1'b1;
    lane_exp = {25'h1ffffff, 25'h1ffffff, 25'h0, 25'h1ffffff};
    send(1'b1, 8'h20, ONES, ONES);
    send(1'b1, 8'h20, '0, m49);
    chk("lane_ref", ref_mem[8'h20], lane_exp);
    send(1'b0, 8'h20, '0, '0);
    repeat (3) @(posedge clk); #1;

    // Backpressure: two reads fit, the third waits for a pop.
    for (int i = 1; i <= 3; i++) send(1'b1, 8'(i), {4{25'(i * 7 + 3)}}, ONES);
    bus.rsp_rdy = 1'b0;
    send(1'b0, 8'd1, '0, '0);
    send(1'b0, 8'd2, '0, '0);
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy_low", {99'd0, bus.req_rdy}, 100'd0);
      chk("bp_hold", bus.rsp_data, ref_mem[1]);
      @(posedge clk); #1;
    end
    bus.req_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    send(1'b0, 8'd3, '0, '0);
    repeat (4) @(posedge clk); #1;
    chk("bp_drained", 100'(exp_q.size()), 100'd0);

    // Streaming: 16 back-to-back reads, 16 consecutive responses.
    for (int i = 0; i < 16; i++) send(1'b1, 8'(8'h40 + i), {4{25'(i * 1234567)}}, ONES);
    for (int i = 0; i < 16; i++) begin
      bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'(8'h40 + i);
      @(negedge clk);
      chk("stream_rdy", {99'd0, bus.req_rdy}, 100'd1);
      if (bus.req_rdy) exp_q.push_back(ref_mem[8'h40 + i]);
      if (i >= 2) chk("stream_vld", {99'd0, bus.rsp_vld}, 100'd1);
      @(posedge clk); #1;
    end
    bus.req_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_tail", {99'd0, bus.rsp_vld}, {99'd0, i < 2});
      @(posedge clk); #1;
    end
    chk("stream_drained", 100'(exp_q.size()), 100'd0);

    // Reset with one read in flight and one FIFO entry.
    bus.rsp_rdy = 1'b0;
    send(1'b0, 8'd1, '0, '0);
    send(1'b0, 8'd2, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_vld", {99'd0, bus.rsp_vld}, 100'd0);
    exp_q.delete();
    do_reset();
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_quiet", {99'd0, bus.rsp_vld}, 100'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
